// File: rtl/lm_sm_sequencer_if.sv
// Bundle between pipe1, the LM/SM sequencer and the decode stage.
// master = pipe1/decode side, slave = the sequencer.
interface lm_sm_sequencer_if #(
  parameter int REG_W = 3
);
  logic             valid_in;
  logic [15:0]      IR;
  logic             stall_in;
  logic             flush;
  logic             stall_out;
  logic             uop_valid;
  logic [15:0]      uop_IR;
  logic [REG_W-1:0] uop_reg;
  logic [REG_W-1:0] uop_base;
  logic [REG_W-1:0] uop_offset;
  logic             uop_first;
  logic             uop_last;

  modport master (
    output valid_in, IR, stall_in, flush,
    input  stall_out, uop_valid, uop_IR, uop_reg, uop_base, uop_offset, uop_first, uop_last
  );

  modport slave (
    input  valid_in, IR, stall_in, flush,
    output stall_out, uop_valid, uop_IR, uop_reg, uop_base, uop_offset, uop_first, uop_last
  );
endinterface

// File: rtl/lm_sm_sequencer.sv
// Purpose: expands LM/SM into one micro-op per listed register; other instructions pass through.
// Latency: one registered cycle; an N-register LM/SM occupies N consecutive unstalled cycles.
// Backpressure: stall_in freezes all state; stall_out holds pipe1 while the expansion runs.
module lm_sm_sequencer #(
  parameter int         NUM_REGS = 8,
  parameter int         REG_W    = 3,
  parameter logic [3:0] OP_LM    = 4'b0110,
  parameter logic [3:0] OP_SM    = 4'b0111
) (
  input logic              clk,
  input logic              reset_n,
  lm_sm_sequencer_if.slave bus
);

  typedef enum logic {IDLE, SEQ} state_t;

  state_t              state;
  logic [NUM_REGS-1:0] mask;
  logic [3:0]          parent_op;
  logic [8:0]          parent_lo;

  logic             uop_valid_q;
  logic [15:0]      uop_ir_q;
  logic [REG_W-1:0] uop_reg_q;
  logic [REG_W-1:0] uop_base_q;
  logic [REG_W-1:0] uop_offset_q;
  logic             uop_first_q;
  logic             uop_last_q;

  function automatic logic [REG_W-1:0] lowest_bit(input logic [NUM_REGS-1:0] v);
    logic [REG_W-1:0] idx;
    idx = '0;
    for (int i = NUM_REGS - 1; i >= 0; i--) begin
      if (v[i]) idx = REG_W'(i);
    end
    return idx;
  endfunction

  function automatic logic [NUM_REGS-1:0] onehot(input logic [REG_W-1:0] idx);
    return {{(NUM_REGS-1){1'b0}}, 1'b1} << idx;
  endfunction

  logic                is_lmsm;
  logic [NUM_REGS-1:0] in_list;
  logic [REG_W-1:0]    in_k;
  logic [NUM_REGS-1:0] in_rem;
  logic [REG_W-1:0]    seq_j;
  logic [NUM_REGS-1:0] seq_rem;

  assign is_lmsm = (bus.IR[15:12] == OP_LM) || (bus.IR[15:12] == OP_SM);
  assign in_list = bus.IR[NUM_REGS-1:0];
  assign in_k    = lowest_bit(in_list);
  assign in_rem  = in_list & ~onehot(in_k);
  assign seq_j   = lowest_bit(mask);
  assign seq_rem = mask & ~onehot(seq_j);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      mask         <= '0;
      parent_op    <= '0;
      parent_lo    <= '0;
      uop_valid_q  <= 1'b0;
      uop_ir_q     <= '0;
      uop_reg_q    <= '0;
      uop_base_q   <= '0;
      uop_offset_q <= '0;
      uop_first_q  <= 1'b0;
      uop_last_q   <= 1'b0;
    end else if (bus.flush) begin
      state        <= IDLE;
      mask         <= '0;
      uop_offset_q <= '0;
      uop_valid_q  <= 1'b0;
    end else if (!bus.stall_in) begin
      case (state)
        IDLE: begin
          if (!bus.valid_in) begin
            uop_valid_q <= 1'b0;
          end else if (!is_lmsm) begin
            uop_valid_q  <= 1'b1;
            uop_ir_q     <= bus.IR;
            uop_reg_q    <= '0;
            uop_base_q   <= bus.IR[9 +: REG_W];
            uop_offset_q <= '0;
            uop_first_q  <= 1'b1;
            uop_last_q   <= 1'b1;
          end else if (in_list == '0) begin
            // empty register list retires silently as a NOP
            uop_valid_q <= 1'b0;
          end else begin
            uop_valid_q  <= 1'b1;
            uop_ir_q     <= {bus.IR[15:12], in_k, bus.IR[8:0]};
            uop_reg_q    <= in_k;
            uop_base_q   <= bus.IR[9 +: REG_W];
            uop_offset_q <= '0;
            uop_first_q  <= 1'b1;
            uop_last_q   <= (in_rem == '0);
            parent_op    <= bus.IR[15:12];
            parent_lo    <= bus.IR[8:0];
            mask         <= in_rem;
            state        <= (in_rem != '0) ? SEQ : IDLE;
          end
        end
        SEQ: begin
          // pipe1 is held here, so only the latched parent fields are used
          uop_valid_q  <= 1'b1;
          uop_ir_q     <= {parent_op, seq_j, parent_lo};
          uop_reg_q    <= seq_j;
          uop_offset_q <= uop_offset_q + 1'b1;
          uop_first_q  <= 1'b0;
          uop_last_q   <= (seq_rem == '0);
          mask         <= seq_rem;
          state        <= (seq_rem != '0) ? SEQ : IDLE;
        end
      endcase
    end
  end

  assign bus.stall_out  = (state == SEQ) | bus.stall_in;
  assign bus.uop_valid  = uop_valid_q;
  assign bus.uop_IR     = uop_ir_q;
  assign bus.uop_reg    = uop_reg_q;
  assign bus.uop_base   = uop_base_q;
  assign bus.uop_offset = uop_offset_q;
  assign bus.uop_first  = uop_first_q;
  assign bus.uop_last   = uop_last_q;

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// Bench for lm_sm_sequencer: queue-based reference model checked every cycle plus literal expectations.
module tb_lm_sm_sequencer;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  lm_sm_sequencer_if #(.REG_W(3)) bus ();

  lm_sm_sequencer dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [15:0] ir;
    logic [2:0]  r;
    logic [2:0]  base;
    logic [2:0]  ofs;
    logic        first;
    logic        last;
  } uop_t;

  // Model: every accepted instruction becomes a list of micro-ops; one is shown per unstalled edge.
  uop_t q[$];
  uop_t lst[$];
  uop_t exp_uop = '0;
  logic exp_vld = 1'b0;

  always @(posedge clk or negedge reset_n) begin
    uop_t u;
    if (!reset_n) begin
      q.delete();
      exp_uop = '0;
      exp_vld = 1'b0;
    end else if (bus.flush) begin
      q.delete();
      exp_vld = 1'b0;
    end else if (!bus.stall_in) begin
      if (q.size() != 0) begin
        exp_uop = q.pop_front();
        exp_vld = 1'b1;
      end else if (bus.valid_in) begin
        lst.delete();
        if (bus.IR[15:12] == 4'd6 || bus.IR[15:12] == 4'd7) begin
          for (int b = 0; b < 8; b++) begin
            if (bus.IR[b]) begin
              u        = '0;
              u.ir     = bus.IR;
              u.ir[11:9] = 3'(b);
              u.r      = 3'(b);
              u.base   = bus.IR[11:9];
              u.ofs    = 3'(lst.size());
              u.first  = (lst.size() == 0);
              u.last   = 1'b0;
              lst.push_back(u);
            end
          end
          if (lst.size() != 0) lst[lst.size()-1].last = 1'b1;
        end else begin
          u       = '0;
          u.ir    = bus.IR;
          u.base  = bus.IR[11:9];
          u.first = 1'b1;
          u.last  = 1'b1;
          lst.push_back(u);
        end
        if (lst.size() == 0) begin
          exp_vld = 1'b0;
        end else begin
          exp_uop = lst.pop_front();
          exp_vld = 1'b1;
          q = lst;
        end
      end else begin
        exp_vld = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      check("model stall_out", 32'(bus.stall_out), 32'((q.size() != 0) | bus.stall_in));
      check("model uop_valid", 32'(bus.uop_valid), 32'(exp_vld));
      if (exp_vld) begin
        check("model uop_IR",     32'(bus.uop_IR),     32'(exp_uop.ir));
        check("model uop_reg",    32'(bus.uop_reg),    32'(exp_uop.r));
        check("model uop_base",   32'(bus.uop_base),   32'(exp_uop.base));
        check("model uop_offset", 32'(bus.uop_offset), 32'(exp_uop.ofs));
        check("model uop_first",  32'(bus.uop_first),  32'(exp_uop.first));
        check("model uop_last",   32'(bus.uop_last),   32'(exp_uop.last));
      end
    end
  endtask

  task automatic cyc(input logic v, input logic [15:0] ir, input logic st, input logic fl);
    bus.valid_in = v;
    bus.IR       = ir;
    bus.stall_in = st;
    bus.flush    = fl;
    @(posedge clk);
    #2;
  endtask

  task automatic check_zero(input string tag);
    check({tag, " uop_valid"},  32'(bus.uop_valid),  32'd0);
    check({tag, " uop_IR"},     32'(bus.uop_IR),     32'd0);
    check({tag, " uop_reg"},    32'(bus.uop_reg),    32'd0);
    check({tag, " uop_base"},   32'(bus.uop_base),   32'd0);
    check({tag, " uop_offset"}, 32'(bus.uop_offset), 32'd0);
    check({tag, " uop_first"},  32'(bus.uop_first),  32'd0);
    check({tag, " uop_last"},   32'(bus.uop_last),   32'd0);
    check({tag, " stall_out"},  32'(bus.stall_out),  32'd0);
  endtask

  initial begin
    bus.valid_in = 1'b0;
    bus.IR       = '0;
    bus.stall_in = 1'b0;
    bus.flush    = 1'b0;
    #2 reset_n = 1'b0;
    fork
      compare_loop();
    join_none
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    check_zero("reset");

    // passthrough ADD
    cyc(1'b1, 16'h0A58, 1'b0, 1'b0);
    check("add valid", 32'(bus.uop_valid), 32'd1);
    check("add IR",    32'(bus.uop_IR),    32'h0A58);
    check("add base",  32'(bus.uop_base),  32'd5);
    check("add first", 32'(bus.uop_first), 32'd1);
    check("add last",  32'(bus.uop_last),  32'd1);
    check("add stall", 32'(bus.stall_out), 32'd0);

    // LM RA=3 list 00100101
    cyc(1'b1, 16'h6625, 1'b0, 1'b0);
    check("lm0 IR",    32'(bus.uop_IR),    32'h6025);
    check("lm0 reg",   32'(bus.uop_reg),   32'd0);
    check("lm0 first", 32'(bus.uop_first), 32'd1);
    check("lm0 last",  32'(bus.uop_last),  32'd0);
    check("lm0 base",  32'(bus.uop_base),  32'd3);
    check("lm0 stall", 32'(bus.stall_out), 32'd1);
    cyc(1'b1, 16'h6625, 1'b0, 1'b0);
    check("lm1 IR",    32'(bus.uop_IR),     32'h6425);
    check("lm1 reg",   32'(bus.uop_reg),    32'd2);
    check("lm1 ofs",   32'(bus.uop_offset), 32'd1);
    check("lm1 stall", 32'(bus.stall_out),  32'd1);
    cyc(1'b1, 16'h6625, 1'b0, 1'b0);
    check("lm2 IR",    32'(bus.uop_IR),     32'h6A25);
    check("lm2 reg",   32'(bus.uop_reg),    32'd5);
    check("lm2 ofs",   32'(bus.uop_offset), 32'd2);
    check("lm2 last",  32'(bus.uop_last),   32'd1);
    check("lm2 stall", 32'(bus.stall_out),  32'd0);
    cyc(1'b1, 16'h1234, 1'b0, 1'b0);
    check("after lm IR", 32'(bus.uop_IR), 32'h1234);

    // SM RA=2 full list with a two-cycle downstream stall after the 3rd micro-op
    repeat (3) cyc(1'b1, 16'h74FF, 1'b0, 1'b0);
    check("sm2 reg", 32'(bus.uop_reg), 32'd2);
    repeat (2) cyc(1'b1, 16'h74FF, 1'b1, 1'b0);
    check("sm held reg",   32'(bus.uop_reg),    32'd2);
    check("sm held ofs",   32'(bus.uop_offset), 32'd2);
    check("sm held stall", 32'(bus.stall_out),  32'd1);
    repeat (5) cyc(1'b1, 16'h74FF, 1'b0, 1'b0);
    check("sm7 IR",   32'(bus.uop_IR),     32'h7EFF);
    check("sm7 reg",  32'(bus.uop_reg),    32'd7);
    check("sm7 ofs",  32'(bus.uop_offset), 32'd7);
    check("sm7 last", 32'(bus.uop_last),   32'd1);

    // LM with empty list is a NOP
    cyc(1'b1, 16'h6000, 1'b0, 1'b0);
    check("empty valid", 32'(bus.uop_valid), 32'd0);
    check("empty stall", 32'(bus.stall_out), 32'd0);
    cyc(1'b1, 16'h0A58, 1'b0, 1'b0);
    check("after empty IR", 32'(bus.uop_IR), 32'h0A58);

    // flush after the 2nd micro-op of LM 00001111
    repeat (2) cyc(1'b1, 16'h600F, 1'b0, 1'b0);
    check("fl1 reg", 32'(bus.uop_reg), 32'd1);
    cyc(1'b1, 16'h600F, 1'b0, 1'b1);
    check("flush valid", 32'(bus.uop_valid), 32'd0);
    check("flush stall", 32'(bus.stall_out), 32'd0);
    repeat (3) cyc(1'b0, 16'h0000, 1'b0, 1'b0);
    check("post flush valid", 32'(bus.uop_valid), 32'd0);

    // single-bit LM
    cyc(1'b1, 16'h6080, 1'b0, 1'b0);
    check("one IR",    32'(bus.uop_IR),     32'h6E80);
    check("one reg",   32'(bus.uop_reg),    32'd7);
    check("one ofs",   32'(bus.uop_offset), 32'd0);
    check("one first", 32'(bus.uop_first),  32'd1);
    check("one last",  32'(bus.uop_last),   32'd1);
    check("one stall", 32'(bus.stall_out),  32'd0);
    cyc(1'b0, 16'h0000, 1'b0, 1'b0);

    // asynchronous reset in the middle of an expansion
    cyc(1'b1, 16'h600F, 1'b0, 1'b0);
    check("pre reset stall", 32'(bus.stall_out), 32'd1);
    reset_n = 1'b0;
    #1;
    check_zero("mid reset");
    @(posedge clk);
    #2 reset_n = 1'b1;
    cyc(1'b1, 16'h0A58, 1'b0, 1'b0);
    check("post reset IR",    32'(bus.uop_IR),    32'h0A58);
    check("post reset valid", 32'(bus.uop_valid), 32'd1);
    cyc(1'b0, 16'h0000, 1'b0, 1'b0);
    cyc(1'b0, 16'h0000, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
